// File: rtl/imem_arbiter_if.sv
// Shared instruction-memory bus bundle: fetch read port, loader write port,
// single-port memory interface and boot status. slave = arbiter side.
interface imem_arbiter_if #(
  parameter int IMEM_DEPTH = 14
) ();
  // Fetch stage
  logic                  fetch_req;
  logic [IMEM_DEPTH-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_valid;
  logic [15:0]           fetch_inst;

  // Program loader
  logic                  load_req;
  logic [IMEM_DEPTH-1:0] load_addr;
  logic [15:0]           load_data;
  logic                  load_done;
  logic                  load_gnt;

  // Memory port
  logic [IMEM_DEPTH-1:0] mem_addr;
  logic                  mem_we;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;

  logic                  booting;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_valid, fetch_inst,
    input  load_req, load_addr, load_data, load_done,
    output load_gnt,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output booting
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_valid, fetch_inst,
    output load_req, load_addr, load_data, load_done,
    input  load_gnt,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  booting
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: grants same cycle, read data one cycle later.
// Loader-priority with bounded fetch starvation; fetch blocked until the boot image completes.
module imem_arbiter #(
  parameter int IMEM_DEPTH     = 14,
  parameter int MAX_LOAD_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  imem_arbiter_if.slave  bus
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_LOAD_BURST);

  state_e                state_q, state_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic [15:0]           inst_hold_q, inst_hold_d;

  logic                  fetch_wins;
  logic                  fetch_gnt;
  logic                  load_gnt;
  logic [IMEM_DEPTH-1:0] mem_addr;
  logic [15:0]           fetch_inst;

  // Arbitration, burst tracking and next-state logic.
  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    fetch_wins    = 1'b0;
    fetch_gnt     = 1'b0;
    load_gnt      = 1'b0;
    mem_addr      = bus.fetch_addr;
    fetch_valid_d = 1'b0;
    inst_hold_d   = inst_hold_q;
    fetch_inst    = inst_hold_q;

    case (state_q)
      BOOT: begin
        load_gnt = bus.load_req;
        if (bus.load_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        fetch_wins = bus.fetch_req &&
                     (!bus.load_req || (burst_cnt_q == BURST_MAX));
        fetch_gnt  = fetch_wins;
        load_gnt   = bus.load_req && !fetch_wins;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // Counts loader wins that a waiting fetch has had to sit through.
    if (!bus.fetch_req || fetch_gnt) begin
      burst_cnt_d = 4'd0;
    end else if (load_gnt && (burst_cnt_q < BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end

    if (load_gnt) begin
      mem_addr = bus.load_addr;
    end

    fetch_valid_d = fetch_gnt;
    if (fetch_valid_q) begin
      inst_hold_d = bus.mem_rdata;
      fetch_inst  = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      burst_cnt_q   <= 4'd0;
      fetch_valid_q <= 1'b0;
      inst_hold_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      inst_hold_q   <= inst_hold_d;
    end
  end

  // Write enable is deliberately not gated by rst: a write in the reset cycle still lands.
  assign bus.fetch_gnt   = fetch_gnt;
  assign bus.load_gnt    = load_gnt;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_we      = load_gnt;
  assign bus.mem_wdata   = bus.load_data;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_inst  = fetch_inst;
  assign bus.booting     = (state_q == BOOT);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed plus randomized bench for imem_arbiter against a cycle-level reference model.
module tb_imem_arbiter;
  localparam int AW  = 14;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if #(.IMEM_DEPTH(AW)) bus ();

  imem_arbiter #(.IMEM_DEPTH(AW), .MAX_LOAD_BURST(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous single-port memory: read data one cycle after address.
  logic [15:0] tb_mem [0:(1<<AW)-1] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= tb_mem[bus.mem_addr];
  end

  // Reference model state.
  logic [15:0] ref_mem [0:(1<<AW)-1] = '{default: 16'h0000};
  bit          m_run;
  int          m_waited;
  bit          m_valid;
  logic [15:0] m_data;
  logic [15:0] m_hold;

  int checks   = 0;
  int failures = 0;

  // Values observed in the most recent cycle.
  logic        obs_fg, obs_lg, obs_valid, obs_boot;
  logic [15:0] obs_inst, obs_hold;
  logic [3:0]  obs_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit fr, input logic [AW-1:0] fa,
                       input bit lr, input logic [AW-1:0] la, input logic [15:0] ld,
                       input bit dn);
    bit fetch_wins, e_fg, e_lg;
    rst            = r;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.load_req   = lr;
    bus.load_addr  = la;
    bus.load_data  = ld;
    bus.load_done  = dn;
    @(negedge clk);
    fetch_wins = m_run && fr && (!lr || m_waited == MAX);
    e_fg = fetch_wins;
    e_lg = lr && !fetch_wins;
    obs_fg    = bus.fetch_gnt;
    obs_lg    = bus.load_gnt;
    obs_valid = bus.fetch_valid;
    obs_inst  = bus.fetch_inst;
    obs_boot  = bus.booting;
    obs_hold  = dut.inst_hold_q;
    obs_cnt   = dut.burst_cnt_q;
    check("fetch_gnt",   32'(obs_fg),        32'(e_fg));
    check("load_gnt",    32'(obs_lg),        32'(e_lg));
    check("mem_we",      32'(bus.mem_we),    32'(e_lg));
    check("mem_addr",    32'(bus.mem_addr),  32'(e_lg ? la : fa));
    check("mem_wdata",   32'(bus.mem_wdata), 32'(ld));
    check("fetch_valid", 32'(obs_valid),     32'(m_valid));
    check("fetch_inst",  32'(obs_inst),      32'(m_valid ? m_data : m_hold));
    check("booting",     32'(obs_boot),      32'(!m_run));
    @(posedge clk);
    if (e_lg) ref_mem[la] = ld;
    if (r) begin
      m_run = 0; m_waited = 0; m_valid = 0; m_hold = 16'h0;
    end else begin
      if (m_valid) m_hold = m_data;
      m_valid = e_fg;
      if (e_fg) m_data = ref_mem[fa];
      if (!fr || e_fg) m_waited = 0;
      else if (e_lg && m_waited < MAX) m_waited++;
      if (!m_run && dn) m_run = 1;
    end
    #1;
  endtask

  initial begin
    m_run = 0; m_waited = 0; m_valid = 0; m_data = 16'h0; m_hold = 16'h0;
    bus.fetch_req = 0; bus.fetch_addr = '0; bus.load_req = 0;
    bus.load_addr = '0; bus.load_data = '0; bus.load_done = 0;
    @(posedge clk); #1;

    // Reset, then fetch held off during boot.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("reset_booting", 32'(obs_boot), 1);
    check("reset_valid", 32'(obs_valid), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 14'h0000, 0, 0, 0, 0);
      check($sformatf("boot_gate_%0d", i), 32'(obs_fg), 0);
    end
    cycle(0, 1, 14'h0000, 1, 14'h0010, 16'hBEEF, 0);
    check("boot_write_gnt", 32'(obs_lg), 1);
    cycle(0, 1, 14'h0000, 0, 0, 0, 1);
    check("done_cycle_no_fetch", 32'(obs_fg), 0);
    cycle(0, 1, 14'h0010, 0, 0, 0, 0);
    check("run_booting", 32'(obs_boot), 0);
    check("first_fetch_gnt", 32'(obs_fg), 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("boot_read_valid", 32'(obs_valid), 1);
    check("boot_read_data", 32'(obs_inst), 32'hBEEF);

    // Starvation bound: L,L,L,L,F repeating.
    for (int i = 0; i < 15; i++) begin
      cycle(0, 1, 14'(100 + i), 1, 14'(200 + i), 16'($urandom), 0);
      check($sformatf("starve_fgnt_%0d", i), 32'(obs_fg), 32'((i % 5) == 4));
      check($sformatf("starve_cnt_%0d", i), 32'(obs_cnt <= 4'(MAX)), 1);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Streaming fetch of words 0..7.
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 14'(i), 16'(16'hA000 + i), 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 14'(i), 0, 0, 0, 0);
      if (i > 0) begin
        check($sformatf("stream_valid_%0d", i), 32'(obs_valid), 1);
        check($sformatf("stream_data_%0d", i), 32'(obs_inst), 32'(16'hA000 + i - 1));
      end
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("stream_last_valid", 32'(obs_valid), 1);
    check("stream_last_data", 32'(obs_inst), 32'hA007);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("stream_hold_valid", 32'(obs_valid), 0);
    check("stream_hold_data", 32'(obs_inst), 32'hA007);

    // Randomized traffic on a small address window so reads follow writes.
    for (int i = 0; i < 400; i++) begin
      cycle(0, ($urandom_range(0, 9) < 7), 14'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1), 14'($urandom_range(0, 15)),
            16'($urandom), ($urandom_range(0, 9) == 0));
      check("rand_cnt_bound", 32'(obs_cnt <= 4'(MAX)), 1);
    end

    // Reset in the same cycle as a fetch grant; a write in a reset cycle still lands.
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 14'h0005, 0, 0, 0, 0);
    check("midrst_fetch_gnt", 32'(obs_fg), 1);
    cycle(1, 0, 0, 1, 14'h0020, 16'h5555, 0);
    check("midrst_valid", 32'(obs_valid), 0);
    check("midrst_booting", 32'(obs_boot), 1);
    check("midrst_hold", 32'(obs_hold), 0);
    check("rst_cycle_we", 32'(bus.mem_we), 1);

    // Write and load_done together in BOOT.
    cycle(0, 0, 0, 1, 14'h0003, 16'h1234, 1);
    check("simul_load_gnt", 32'(obs_lg), 1);
    cycle(0, 1, 14'h0003, 0, 0, 0, 0);
    check("simul_run", 32'(obs_boot), 0);
    cycle(0, 1, 14'h0020, 0, 0, 0, 0);
    check("simul_read_data", 32'(obs_inst), 32'h1234);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("rst_write_data", 32'(obs_inst), 32'h5555);
    cycle(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-cycle arbiter and sequencer for the single-port instruction memory. It shares the memory between the CPU fetch stage (reads) and the program loader (writes from the UART/debug bootloader). After reset, fetch is held off until the loader signals that the boot image is complete. After that, loader writes and fetches share the port under bounded-starvation priority.

## Interface
- IMEM_DEPTH, 14, address width in 16-bit words; must match the memory's address width.
- MAX_LOAD_BURST, 4, maximum consecutive loader grants while a fetch is pending; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch stage requests a read of fetch_addr.
- fetch_addr  in  IMEM_DEPTH  fetch word address.
- fetch_gnt  out  1  combinational; the read is issued this cycle.
- fetch_valid  out  1  registered; asserted one cycle after fetch_gnt.
- fetch_inst  out  16  instruction word; meaningful while fetch_valid is high, otherwise holds the last valid word.
- load_req  in  1  loader requests a write.
- load_addr  in  IMEM_DEPTH  write word address.
- load_data  in  16  write data.
- load_done  in  1  single-cycle pulse; the boot image is complete.
- load_gnt  out  1  combinational; the write is issued this cycle.
- mem_addr  out  IMEM_DEPTH  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; valid in cycle N+1 for an address presented in cycle N.
- booting  out  1  high while in state BOOT.

## Operation
- FSM states:
  - BOOT (reset state): only loader writes are granted; fetch_gnt=0.
  - RUN: both requesters arbitrate.
- BOOT -> RUN on the cycle after load_done=1. If load_req and load_done are both high in the same cycle, the write is granted in that same cycle.
- RUN -> BOOT only via rst.
- At most one access per cycle: fetch_gnt & load_gnt is never 1.
- Arbitration in RUN:
  - Loader wins by default.
  - Fetch wins if load_req=0, or if burst_cnt==MAX_LOAD_BURST and fetch_req=1.
- burst_cnt (4-bit):
  - Increments on each load_gnt while fetch_req=1.
  - Clears on fetch_gnt, or on any cycle with fetch_req=0.
  - Never exceeds MAX_LOAD_BURST.
- Memory drive:
  - load_gnt: mem_addr=load_addr, mem_we=1, mem_wdata=load_data.
  - Otherwise: mem_addr=fetch_addr, mem_we=0, and mem_wdata=load_data (don't-care).
  - Idle cycles still present fetch_addr with mem_we=0.
- Read return:
  - fetch_valid is fetch_gnt registered.
  - fetch_inst = fetch_valid ? mem_rdata : inst_hold.
  - inst_hold captures mem_rdata on each cycle fetch_valid=1.
- A requester keeps req and address/data stable until it sees its gnt. The arbiter does not latch requests.
- Write then read of the same address in consecutive cycles returns the new data. This relies on the memory's write-before-next-read behaviour; no bypass is added here.

## Timing
- Reset values: state=BOOT, burst_cnt=0, fetch_valid=0, inst_hold=0, booting=1. Combinational outputs follow their equations with fetch_gnt=0 in BOOT.
- Grant latency: 0 cycles (same cycle as req, when it wins).
- Fetch data latency: fetch_valid in cycle N+1 for a grant in cycle N. Back-to-back grants give one word per cycle.
- Worst-case fetch wait in RUN under continuous load_req: MAX_LOAD_BURST cycles.
- First possible fetch_gnt: the cycle after load_done.
- Reset asserted mid-operation:
  - A read in flight is discarded: fetch_valid=0 on the cycle after the rst edge.
  - The FSM returns to BOOT regardless of state.
  - A write issued in the rst cycle still occurs; rst does not gate mem_we.
- load_done in RUN is ignored.

## Test plan
- Boot gating: rst 2 cycles, then fetch_req=1 with addr 0x0000 and no load_done for 10 cycles -> fetch_gnt=0 throughout, booting=1. Then pulse load_done -> next cycle booting=0 and fetch_gnt=1.
- Boot write: in BOOT, write 0xBEEF to 0x0010, load_done, then fetch 0x0010 -> fetch_valid=1 one cycle after fetch_gnt, fetch_inst=0xBEEF.
- Starvation bound: RUN, MAX_LOAD_BURST=4, load_req and fetch_req held high -> grant pattern L,L,L,L,F repeating. burst_cnt never exceeds 4.
- Streaming fetch: RUN, load_req=0, fetch addrs 0x0..0x7 on consecutive cycles -> 8 consecutive fetch_valid cycles with data in address order. After the stream, fetch_inst holds word 0x7.
- Simultaneous load_req and load_done in BOOT, with write 0x1234 to 0x0003 -> load_gnt=1 and mem_we=1 that cycle. State is RUN the next cycle.
- Mid-read reset: fetch_gnt in cycle N, rst in cycle N -> fetch_valid=0 in N+1, booting=1, inst_hold=0.
